// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with write-through bypass and busy scoreboard
// r0 is hardwired to zero; a same-cycle writeback is forwarded as ready data on every read port.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic                     busy_any
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok  = wr_en && (wr_addr != '0);
  assign iss_ok = iss_en && (iss_addr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Issue is applied after the writeback clear so a new producer wins on the same index.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_ok) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic              hit;
      a   = rd_addr[i*ADDR_W +: ADDR_W];
      hit = wr_en && (wr_addr == a);
      if (a == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : mem_q[a];
        rd_busy[i]                  = busy_q[a] && !hit;
      end
    end
  end

  assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed-vector bench for regfile_sb, default and widened configurations
module tb_regfile_sb;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_vec;
    int   n_err;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_iss_en;
    logic [4:0]  a_iss_addr;
    logic        a_flush;
    logic        a_busy_any;

    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_iss_en;
    logic [3:0]   b_iss_addr;
    logic         b_flush;
    logic         b_busy_any;

    regfile_sb u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .rd_busy  (a_rd_busy),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .iss_en   (a_iss_en),
        .iss_addr (a_iss_addr),
        .flush    (a_flush),
        .busy_any (a_busy_any)
    );

    regfile_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_busy  (b_rd_busy),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .iss_en   (b_iss_en),
        .iss_addr (b_iss_addr),
        .flush    (b_flush),
        .busy_any (b_busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        a_rd_addr = '0; a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_en = 0; a_iss_addr = '0; a_flush = 0;
        b_rd_addr = '0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_en = 0; b_iss_addr = '0; b_flush = 0;

        #2 rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("a_reset_busy_any", a_busy_any, 1'b0);
        chk("a_reset_rd_data", a_rd_data, 64'h0);
        chk("a_reset_rd_busy", a_rd_busy, 2'b00);
        chk("b_reset_busy_any", b_busy_any, 1'b0);
        chk("b_reset_rd_data", b_rd_data, 256'h0);

        a_wr_en = 1; a_wr_addr = 5'd5; a_wr_data = 32'h1111_1111;
        a_iss_en = 1; a_iss_addr = 5'd5;
        tick();
        a_wr_en = 0; a_iss_en = 0; a_rd_addr = {5'd0, 5'd5};
        #1;
        chk("a_reset_wr_ignored", a_rd_data[31:0], 32'h0);
        chk("a_reset_iss_ignored", a_busy_any, 1'b0);
        rst_a = 1'b1; rst_b = 1'b1;

        tick();
        a_wr_en = 1; a_wr_addr = 5'd5; a_wr_data = 32'hDEAD_BEEF;
        a_iss_en = 1; a_iss_addr = 5'd6;
        tick();
        a_wr_en = 0; a_iss_en = 0; a_rd_addr = {5'd6, 5'd5};
        #1;
        chk("a_r5_written", a_rd_data[31:0], 32'hDEAD_BEEF);
        chk("a_r6_busy", a_rd_busy, 2'b10);
        #2 rst_a = 1'b0;
        #1;
        chk("a_async_rst_data", a_rd_data[31:0], 32'h0);
        chk("a_async_rst_busy_any", a_busy_any, 1'b0);
        chk("a_async_rst_rd_busy", a_rd_busy, 2'b00);
        #1 rst_a = 1'b1;

        tick();
        a_wr_en = 1; a_wr_addr = 5'd7; a_wr_data = 32'h1234;
        a_rd_addr = {5'd0, 5'd7};
        #1;
        chk("a_bypass_port0", a_rd_data[31:0], 32'h1234);
        chk("a_bypass_port1_r0", a_rd_data[63:32], 32'h0);
        tick();
        a_wr_en = 0;
        #1;
        chk("a_mem_port0", a_rd_data[31:0], 32'h1234);
        a_wr_en = 1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFF;
        a_rd_addr = {5'd7, 5'd0};
        #1;
        chk("a_r0_no_bypass", a_rd_data[31:0], 32'h0);
        tick();
        a_wr_en = 0;
        #1;
        chk("a_r0_after_write", a_rd_data, {32'h1234, 32'h0});

        a_iss_en = 1; a_iss_addr = 5'd3; a_rd_addr = {5'd3, 5'd3};
        #1;
        chk("a_iss_not_yet_visible", a_rd_busy, 2'b00);
        tick();
        a_iss_en = 0;
        #1;
        chk("a_iss_visible", a_rd_busy, 2'b11);
        chk("a_iss_busy_any", a_busy_any, 1'b1);
        a_wr_en = 1; a_wr_addr = 5'd3; a_wr_data = 32'hA5;
        #1;
        chk("a_wb_masks_busy", a_rd_busy, 2'b00);
        chk("a_wb_bypass_data", a_rd_data, {32'hA5, 32'hA5});
        chk("a_wb_busy_any_registered", a_busy_any, 1'b1);
        tick();
        a_wr_en = 0;
        #1;
        chk("a_wb_cleared", a_rd_busy, 2'b00);
        chk("a_wb_busy_any_clear", a_busy_any, 1'b0);
        chk("a_wb_mem", a_rd_data[31:0], 32'hA5);

        a_iss_en = 1; a_iss_addr = 5'd9;
        tick();
        a_wr_en = 1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
        tick();
        a_wr_en = 0; a_iss_en = 0; a_rd_addr = {5'd0, 5'd9};
        #1;
        chk("a_r9_data", a_rd_data[31:0], 32'h99);
        chk("a_r9_still_busy", a_rd_busy, 2'b01);
        a_iss_en = 1; a_iss_addr = 5'd0;
        tick();
        a_iss_en = 0;
        #1;
        chk("a_iss_r0_busy_any", a_busy_any, 1'b1);
        chk("a_iss_r0_rd_busy", a_rd_busy, 2'b01);
        a_wr_en = 1; a_wr_addr = 5'd9; a_wr_data = 32'h9A;
        tick();
        a_wr_en = 0;
        #1;
        chk("a_r9_released", a_busy_any, 1'b0);

        a_iss_en = 1; a_iss_addr = 5'd1; tick();
        a_iss_addr = 5'd2; tick();
        a_iss_addr = 5'd31; tick();
        a_iss_en = 0; a_rd_addr = {5'd31, 5'd2};
        #1;
        chk("a_pre_flush_busy", a_rd_busy, 2'b11);
        a_flush = 1; a_iss_en = 1; a_iss_addr = 5'd4;
        a_wr_en = 1; a_wr_addr = 5'd2; a_wr_data = 32'h55;
        a_rd_addr = {5'd1, 5'd2};
        #1;
        chk("a_flush_cycle_old_busy", a_rd_busy, 2'b10);
        tick();
        a_flush = 0; a_iss_en = 0; a_wr_en = 0;
        a_rd_addr = {5'd4, 5'd2};
        #1;
        chk("a_flush_busy_any", a_busy_any, 1'b0);
        chk("a_flush_rd_busy", a_rd_busy, 2'b00);
        chk("a_flush_wr_kept", a_rd_data[31:0], 32'h55);

        b_wr_en = 1; b_wr_addr = 4'd7; b_wr_data = 64'h0123_4567_89AB_CDEF;
        b_rd_addr = {4'd5, 4'd7, 4'd0, 4'd7};
        #1;
        chk("b_bypass_4port", b_rd_data,
            {64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF});
        tick();
        b_wr_en = 1; b_wr_addr = 4'd0; b_wr_data = 64'hFFFF;
        #1;
        chk("b_mem_4port_r0_write", b_rd_data,
            {64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF});
        tick();
        b_wr_en = 0;

        b_iss_en = 1; b_iss_addr = 4'd3;
        b_rd_addr = {4'd3, 4'd15, 4'd3, 4'd3};
        tick();
        b_iss_en = 0;
        #1;
        chk("b_iss_visible", b_rd_busy, 4'b1011);
        chk("b_iss_busy_any", b_busy_any, 1'b1);
        b_wr_en = 1; b_wr_addr = 4'd3; b_wr_data = 64'hA5;
        #1;
        chk("b_wb_masks_busy", b_rd_busy, 4'b0000);
        chk("b_wb_bypass_port3", b_rd_data[255:192], 64'hA5);
        tick();
        b_wr_en = 0;
        #1;
        chk("b_wb_cleared", b_busy_any, 1'b0);

        b_iss_en = 1; b_iss_addr = 4'd9;
        tick();
        b_wr_en = 1; b_wr_addr = 4'd9; b_wr_data = 64'hFEDC_BA98_7654_3210;
        tick();
        b_wr_en = 0; b_iss_en = 0;
        b_rd_addr = {4'd0, 4'd9, 4'd9, 4'd0};
        #1;
        chk("b_r9_data", b_rd_data[191:64], {64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210});
        chk("b_r9_still_busy", b_rd_busy, 4'b0110);

        b_iss_en = 1; b_iss_addr = 4'd1; tick();
        b_iss_addr = 4'd2; tick();
        b_iss_addr = 4'd15; tick();
        b_iss_en = 0;
        b_flush = 1; b_iss_en = 1; b_iss_addr = 4'd4;
        b_wr_en = 1; b_wr_addr = 4'd2; b_wr_data = 64'h55;
        b_rd_addr = {4'd15, 4'd9, 4'd2, 4'd1};
        #1;
        chk("b_flush_cycle_old_busy", b_rd_busy, 4'b1101);
        tick();
        b_flush = 0; b_iss_en = 0; b_wr_en = 0;
        b_rd_addr = {4'd4, 4'd15, 4'd2, 4'd1};
        #1;
        chk("b_flush_busy_any", b_busy_any, 1'b0);
        chk("b_flush_rd_busy", b_rd_busy, 4'b0000);
        chk("b_flush_wr_kept", b_rd_data[127:64], 64'h55);

        b_iss_en = 1; b_iss_addr = 4'd6;
        tick();
        b_iss_en = 0;
        #1;
        chk("b_pre_rst_busy_any", b_busy_any, 1'b1);
        #1 rst_b = 1'b0;
        #1;
        chk("b_async_rst_data", b_rd_data, 256'h0);
        chk("b_async_rst_busy_any", b_busy_any, 1'b0);
        #1 rst_b = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
